// File: rtl/ov_yuv422_unpacker.sv
// OV7670 YUV422 byte-stream unpacker: turns the D/HREF/VSYNC camera bus into
// one decoded pixel per e_pix strobe with coordinates and line/frame flags.
module ov_yuv422_unpacker #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ORDER    = 0
) (
  input  logic       PCLK,
  input  logic       reset,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] D,
  output logic       e_pix,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       frame_start,
  output logic       line_end,
  output logic       line_err,
  output logic       frame_err
);

  localparam int unsigned BYTES_LINE = 2 * H_ACTIVE;
  localparam int unsigned BW         = $clog2(BYTES_LINE + 2);
  localparam int unsigned XW         = $clog2(H_ACTIVE + 1);
  localparam int unsigned RW         = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    BLANK_V   = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t        state;
  logic          href_q;
  logic          vsync_q;
  logic [1:0]    phase;
  logic [7:0]    slot0;
  logic [7:0]    slot1;
  logic [7:0]    slot2;
  logic [BW-1:0] byte_cnt;
  logic [XW-1:0] grp_x;
  logic [RW-1:0] row;
  logic          line_act;
  logic          pend1;
  logic [7:0]    y1_q;

  logic          vs_fall;
  logic          vs_rise;
  logic          hr_fall;
  logic          take;
  logic [7:0]    g_y0;
  logic [7:0]    g_y1;
  logic [7:0]    g_cb;
  logic [7:0]    g_cr;

  // Edge detection against the registered copies of the sync inputs.
  assign vs_fall = vsync_q & ~VSYNC;
  assign vs_rise = ~vsync_q & VSYNC;
  assign hr_fall = href_q & ~HREF;

  // A byte is accepted only inside an active frame with rows still to fill.
  assign take = (state == ACTIVE) && !VSYNC && HREF && (row < RW'(V_ACTIVE));

  // Decode the 4-byte group; the 4th byte is taken straight from D.
  always_comb begin
    g_y0 = slot1;
    g_y1 = D;
    g_cb = slot0;
    g_cr = slot2;
    if (ORDER == 1) begin
      g_y0 = slot0;
      g_cb = slot1;
      g_y1 = slot2;
      g_cr = D;
    end
  end

  // Frame/line state machine, byte assembly and registered pixel outputs.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state       <= WAIT_SYNC;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      phase       <= 2'd0;
      slot0       <= 8'd0;
      slot1       <= 8'd0;
      slot2       <= 8'd0;
      byte_cnt    <= '0;
      grp_x       <= '0;
      row         <= '0;
      line_act    <= 1'b0;
      pend1       <= 1'b0;
      y1_q        <= 8'd0;
      e_pix       <= 1'b0;
      Y           <= 8'd0;
      Cb          <= 8'd0;
      Cr          <= 8'd0;
      pix_x       <= 10'd0;
      pix_y       <= 9'd0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      href_q      <= HREF;
      vsync_q     <= VSYNC;
      e_pix       <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;

      // Second pixel of a completed group goes out one cycle after the first.
      if (pend1) begin
        e_pix <= 1'b1;
        Y     <= y1_q;
        pix_x <= pix_x + 10'd1;
        pend1 <= 1'b0;
      end

      case (state)
        WAIT_SYNC, BLANK_V: begin
          if (vs_fall) begin
            state       <= ACTIVE;
            frame_start <= 1'b1;
            pix_y       <= 9'd0;
            row         <= '0;
            phase       <= 2'd0;
            byte_cnt    <= '0;
            grp_x       <= '0;
            line_act    <= 1'b0;
          end
        end

        ACTIVE: begin
          if (vs_rise) begin
            // Frame sync arriving mid-line aborts the line without line_end.
            state    <= BLANK_V;
            frame_err <= line_act & HREF;
            line_act <= 1'b0;
            phase    <= 2'd0;
            byte_cnt <= '0;
            grp_x    <= '0;
          end else if (!VSYNC) begin
            if (take) begin
              line_act <= 1'b1;
              phase    <= phase + 2'd1;
              if (byte_cnt < BW'(BYTES_LINE + 1)) begin
                byte_cnt <= byte_cnt + BW'(1);
              end
              case (phase)
                2'd0:    slot0 <= D;
                2'd1:    slot1 <= D;
                2'd2:    slot2 <= D;
                default: begin
                  // Group complete: emit pixel 0 now unless the line is already full.
                  if (grp_x < XW'(H_ACTIVE)) begin
                    e_pix <= 1'b1;
                    Y     <= g_y0;
                    Cb    <= g_cb;
                    Cr    <= g_cr;
                    pix_x <= 10'(grp_x);
                    pix_y <= 9'(row);
                    y1_q  <= g_y1;
                    pend1 <= 1'b1;
                    grp_x <= grp_x + XW'(2);
                  end
                end
              endcase
            end else if (hr_fall && line_act) begin
              line_end <= 1'b1;
              line_err <= (byte_cnt != BW'(BYTES_LINE));
              line_act <= 1'b0;
              phase    <= 2'd0;
              byte_cnt <= '0;
              grp_x    <= '0;
              if (row < RW'(V_ACTIVE)) begin
                row <= row + RW'(1);
              end
            end
          end
        end

        default: state <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ov_yuv422_unpacker.sv
// Scoreboard bench for ov_yuv422_unpacker: two instances (UYVY and YUYV, 4x2 frame).
module tb_ov_yuv422_unpacker;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic [9:0] x;
    logic [8:0] row;
  } pix_t;

  typedef struct packed {
    logic fs;
    logic le;
    logic lerr;
    logic ferr;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_vs = 1'b0, a_hr = 1'b0;
  logic [7:0] a_d = 8'd0;
  logic       b_vs = 1'b0, b_hr = 1'b0;
  logic [7:0] b_d = 8'd0;

  logic       a_e, a_fs, a_le, a_lerr, a_ferr;
  logic [7:0] a_y, a_cb, a_cr;
  logic [9:0] a_x;
  logic [8:0] a_row;
  logic       b_e, b_fs, b_le, b_lerr, b_ferr;
  logic [7:0] b_y, b_cb, b_cr;
  logic [9:0] b_x;
  logic [8:0] b_row;

  pix_t qpa[$];
  pix_t qpb[$];
  ctl_t qca[$];
  ctl_t qcb[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_rst = 1'b0;
  logic fin_chk = 1'b0;
  logic fin_done = 1'b0;

  always #5 clk = ~clk;

  ov_yuv422_unpacker #(.H_ACTIVE(4), .V_ACTIVE(2), .ORDER(0)) u_a (
    .PCLK(clk), .reset(rst), .VSYNC(a_vs), .HREF(a_hr), .D(a_d),
    .e_pix(a_e), .Y(a_y), .Cb(a_cb), .Cr(a_cr), .pix_x(a_x), .pix_y(a_row),
    .frame_start(a_fs), .line_end(a_le), .line_err(a_lerr), .frame_err(a_ferr)
  );

  ov_yuv422_unpacker #(.H_ACTIVE(4), .V_ACTIVE(2), .ORDER(1)) u_b (
    .PCLK(clk), .reset(rst), .VSYNC(b_vs), .HREF(b_hr), .D(b_d),
    .e_pix(b_e), .Y(b_y), .Cb(b_cb), .Cr(b_cr), .pix_x(b_x), .pix_y(b_row),
    .frame_start(b_fs), .line_end(b_le), .line_err(b_lerr), .frame_err(b_ferr)
  );

  // Monitor: pops expectations whenever an instance presents a strobe.
  always @(negedge clk) begin
    pix_t pa, pe;
    ctl_t ca, ce;
    if (chk_rst) begin
      n_tests++;
      if ({a_e, a_fs, a_le, a_lerr, a_ferr} !== 5'b0) begin
        n_fail++;
        $display("FAIL rst_flags got %b want 00000", {a_e, a_fs, a_le, a_lerr, a_ferr});
      end
      n_tests++;
      if ({a_y, a_cb, a_cr, a_x, a_row} !== 43'd0) begin
        n_fail++;
        $display("FAIL rst_data got %h want 0", {a_y, a_cb, a_cr, a_x, a_row});
      end
    end
    if (a_e) begin
      pa = '{a_y, a_cb, a_cr, a_x, a_row};
      n_tests++;
      if (qpa.size() == 0) begin
        n_fail++;
        $display("FAIL a_pix unexpected got y=%h cb=%h cr=%h x=%0d row=%0d want none",
                 pa.y, pa.cb, pa.cr, pa.x, pa.row);
      end else begin
        pe = qpa.pop_front();
        if (pa !== pe) begin
          n_fail++;
          $display("FAIL a_pix got y=%h cb=%h cr=%h x=%0d row=%0d want y=%h cb=%h cr=%h x=%0d row=%0d",
                   pa.y, pa.cb, pa.cr, pa.x, pa.row, pe.y, pe.cb, pe.cr, pe.x, pe.row);
        end
      end
    end
    if (a_fs | a_le | a_lerr | a_ferr) begin
      ca = '{a_fs, a_le, a_lerr, a_ferr};
      n_tests++;
      if (qca.size() == 0) begin
        n_fail++;
        $display("FAIL a_ctl unexpected got fs/le/lerr/ferr=%b want none", ca);
      end else begin
        ce = qca.pop_front();
        if (ca !== ce) begin
          n_fail++;
          $display("FAIL a_ctl got fs/le/lerr/ferr=%b want %b", ca, ce);
        end
      end
    end
    if (b_e) begin
      pa = '{b_y, b_cb, b_cr, b_x, b_row};
      n_tests++;
      if (qpb.size() == 0) begin
        n_fail++;
        $display("FAIL b_pix unexpected got y=%h x=%0d want none", pa.y, pa.x);
      end else begin
        pe = qpb.pop_front();
        if (pa !== pe) begin
          n_fail++;
          $display("FAIL b_pix got y=%h cb=%h cr=%h x=%0d row=%0d want y=%h cb=%h cr=%h x=%0d row=%0d",
                   pa.y, pa.cb, pa.cr, pa.x, pa.row, pe.y, pe.cb, pe.cr, pe.x, pe.row);
        end
      end
    end
    if (b_fs | b_le | b_lerr | b_ferr) begin
      ca = '{b_fs, b_le, b_lerr, b_ferr};
      n_tests++;
      if (qcb.size() == 0) begin
        n_fail++;
        $display("FAIL b_ctl unexpected got fs/le/lerr/ferr=%b want none", ca);
      end else begin
        ce = qcb.pop_front();
        if (ca !== ce) begin
          n_fail++;
          $display("FAIL b_ctl got fs/le/lerr/ferr=%b want %b", ca, ce);
        end
      end
    end
    if (fin_chk && !fin_done) begin
      n_tests++;
      if ((qpa.size() + qpb.size() + qca.size() + qcb.size()) != 0) begin
        n_fail++;
        $display("FAIL drain got %0d/%0d/%0d/%0d pending want 0/0/0/0",
                 qpa.size(), qca.size(), qpb.size(), qcb.size());
      end
      fin_done <= 1'b1;
    end
  end

  task automatic stepa(input logic v, input logic h, input logic [7:0] d);
    a_vs = v; a_hr = h; a_d = d;
    @(posedge clk); #1;
  endtask

  task automatic stepb(input logic v, input logic h, input logic [7:0] d);
    b_vs = v; b_hr = h; b_d = d;
    @(posedge clk); #1;
  endtask

  task automatic push_pa(input logic [7:0] y, cb, cr, input int x, input int r);
    qpa.push_back('{y, cb, cr, 10'(x), 9'(r)});
  endtask

  // New frame on instance A: VSYNC pulse, frame_start expected on its fall.
  task automatic frame_a();
    stepa(1'b1, 1'b0, 8'd0);
    stepa(1'b1, 1'b0, 8'd0);
    qca.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    stepa(1'b0, 1'b0, 8'd0);
    stepa(1'b0, 1'b0, 8'd0);
  endtask

  // UYVY line of n bytes (value base+i) followed by a single low cycle.
  task automatic line_a(input int base, input int n, input int r);
    logic [7:0] b [0:15];
    for (int i = 0; i < 16; i++) b[i] = 8'(base + i);
    if (r < 2) begin
      for (int g = 0; g < n / 4; g++) begin
        if (2 * g < 4) begin
          push_pa(b[4*g+1], b[4*g], b[4*g+2], 2 * g, r);
          push_pa(b[4*g+3], b[4*g], b[4*g+2], 2 * g + 1, r);
        end
      end
      qca.push_back('{1'b0, 1'b1, (n != 8), 1'b0});
    end
    for (int i = 0; i < n; i++) stepa(1'b0, 1'b1, b[i]);
    stepa(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    chk_rst = 1'b1;
    rst = 1'b0;
    stepa(1'b0, 1'b0, 8'd0);
    chk_rst = 1'b0;

    // Reset mid-line after 3 bytes, then a line that must stay silent.
    frame_a();
    stepa(1'b0, 1'b1, 8'h80);
    stepa(1'b0, 1'b1, 8'h10);
    stepa(1'b0, 1'b1, 8'h90);
    rst = 1'b1;
    stepa(1'b0, 1'b1, 8'h20);
    rst = 1'b0;
    chk_rst = 1'b1;
    stepa(1'b0, 1'b1, 8'h81);
    chk_rst = 1'b0;
    stepa(1'b0, 1'b1, 8'h11);
    stepa(1'b0, 1'b1, 8'h91);
    stepa(1'b0, 1'b1, 8'h21);
    stepa(1'b0, 1'b0, 8'h00);
    stepa(1'b0, 1'b0, 8'h00);

    // UYVY hand-computed line 0, then an overlong line and a silent 3rd line.
    frame_a();
    push_pa(8'h10, 8'h80, 8'h90, 0, 0);
    push_pa(8'h20, 8'h80, 8'h90, 1, 0);
    push_pa(8'h11, 8'h81, 8'h91, 2, 0);
    push_pa(8'h21, 8'h81, 8'h91, 3, 0);
    qca.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
    stepa(1'b0, 1'b1, 8'h80);
    stepa(1'b0, 1'b1, 8'h10);
    stepa(1'b0, 1'b1, 8'h90);
    stepa(1'b0, 1'b1, 8'h20);
    stepa(1'b0, 1'b1, 8'h81);
    stepa(1'b0, 1'b1, 8'h11);
    stepa(1'b0, 1'b1, 8'h91);
    stepa(1'b0, 1'b1, 8'h21);
    stepa(1'b0, 1'b0, 8'h00);
    line_a(8'h30, 10, 1);
    line_a(8'h50, 8, 2);

    // Short line (6 bytes) then a full line on row 1.
    frame_a();
    line_a(8'h60, 6, 0);
    line_a(8'h70, 8, 1);

    // Three back-to-back full lines on a 4x2 frame: third is ignored.
    frame_a();
    line_a(8'h00, 8, 0);
    line_a(8'h20, 8, 1);
    line_a(8'h40, 8, 2);

    // VSYNC rises after 5 bytes with HREF still high.
    frame_a();
    push_pa(8'hA1, 8'hA0, 8'hA2, 0, 0);
    push_pa(8'hA3, 8'hA0, 8'hA2, 1, 0);
    for (int i = 0; i < 5; i++) stepa(1'b0, 1'b1, 8'(8'hA0 + i));
    qca.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    stepa(1'b1, 1'b1, 8'hA5);
    stepa(1'b1, 1'b1, 8'hA6);
    stepa(1'b1, 1'b0, 8'h00);
    stepa(1'b1, 1'b0, 8'h00);
    qca.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    stepa(1'b0, 1'b0, 8'h00);
    stepa(1'b0, 1'b0, 8'h00);

    // YUYV instance: bytes 10,80,20,90 give the same two pixels.
    stepb(1'b1, 1'b0, 8'h00);
    stepb(1'b1, 1'b0, 8'h00);
    qcb.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    stepb(1'b0, 1'b0, 8'h00);
    qpb.push_back('{8'h10, 8'h80, 8'h90, 10'd0, 9'd0});
    qpb.push_back('{8'h20, 8'h80, 8'h90, 10'd1, 9'd0});
    qcb.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
    stepb(1'b0, 1'b1, 8'h10);
    stepb(1'b0, 1'b1, 8'h80);
    stepb(1'b0, 1'b1, 8'h20);
    stepb(1'b0, 1'b1, 8'h90);
    stepb(1'b0, 1'b0, 8'h00);

    repeat (6) stepa(1'b0, 1'b0, 8'h00);
    fin_chk = 1'b1;
    guard = 0;
    while (!fin_done && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (!fin_done) begin
      $display("FAIL drain_check timeout got none want one");
      $fatal(1, "drain check never ran");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
